fsm_ab_driver: RTL and testbench
================================

// Module: fsm_ab_driver
// PURPOSE
//  Initiator for the a/b two-input control FSM (states S0,S1,S2; Moore y1, Mealy y0).
//  Accepts steering commands over valid/ready and emits the registered a/b symbols.
//  These symbols move the partner FSM to the requested state or fire one y0 pulse.
//  Keeps a shadow copy of the partner state and checks the partner's y0/y1 against it.
//  Sits beside the partner FSM; both share clk and reset.
// PARAMETERS
//  HOLD_W     8  width of cmd_arg (HOLD cycle count)
//  ERR_CNT_W  8  width of err_count (saturating)
// PORTS
//  clk        in   1         clock, rising edge
//  reset      in   1         synchronous, active-high
//  cmd_valid  in   1         command present
//  cmd_ready  out  1         driver can accept a command
//  cmd_op     in   2         0=GOTO_S0 1=GOTO_S1 2=PULSE_Y0 3=HOLD
//  cmd_arg    in   HOLD_W    HOLD length in cycles; 0 is treated as 1
//  check_en   in   1         enable y0/y1 comparison
//  a, b       out  1 each    registered symbols to the partner FSM
//  y0, y1     in   1 each    partner outputs, same-cycle as a/b
//  done       out  1         1-cycle pulse on the last symbol of a command
//  mismatch   out  1         sticky error flag
//  err_count  out  ERR_CNT_W mismatch cycles, saturates at all-ones
// BEHAVIOUR
//  Reset: a=b=0, shadow=S0, driver IDLE, cmd_ready=1, done=0, mismatch=0, err_count=0.
//  Reset mid-command abandons the command; no done pulse is issued.
//  Partner model, updated on every edge from the current a/b:
//   S0: ab=11->S2, ab=10->S1, a=0->S0.  S1: a=1->S0, else S1.  S2: ->S0.
//   Expected y1 = (shadow!=S2). Expected y0 = (shadow==S0 & a & b).
//  Handshake: accept on cmd_valid & cmd_ready at edge k.
//   - cmd_ready = (driver==IDLE).
//   - The first symbol is driven in cycle k+1.
//   - done is high during the last symbol cycle; cmd_ready returns in the next cycle.
//   - cmd_op/cmd_arg are captured at accept; later changes are ignored.
//  IDLE drives ab=00. Shadow S0/S1 hold; S2 falls to S0.
//  Symbol sequences, chosen from the shadow state at accept:
//   GOTO_S0:  S0:00      S1:10      S2:00        (1 cycle)
//   GOTO_S1:  S0:10      S1:00      S2:00,10     (1-2 cycles)
//   PULSE_Y0: S0:11,00   S1:10,11,00   S2:00,11,00   (always ends in S0)
//   HOLD:     00 for max(cmd_arg,1) cycles
//  Driver FSM: IDLE -> DRIVE (step through the sequence) -> IDLE, or IDLE -> HOLD (down-counter) -> IDLE.
//  Checker: each cycle with check_en=1, compare y0/y1 with the expected values.
//   - Any difference sets mismatch and increments err_count (saturating).
//   - Checking is independent of command state.
//  Only reset clears mismatch and err_count.
// TESTING
//  1. Reset, then PULSE_Y0 from S0 -> ab=11,00; y0 expected 1 then 0; done on the 2nd cycle; err_count=0.
//  2. GOTO_S1 then PULSE_Y0 -> ab=10 | 10,11,00; shadow S1 -> S0 -> S2 -> S0; 4 symbols, 2 done pulses.
//  3. HOLD with arg=0 -> 1 cycle of 00 and done; arg=5 -> 5 cycles of 00, done on the 5th.
//  4. Tie y1=0 with check_en=1 for 3 cycles in S0 -> mismatch=1, err_count=3; ERR_CNT_W=2 saturates at 3.
//  5. cmd_valid held through a 3-symbol PULSE_Y0 -> the next command is accepted only in the cycle after done.
//  6. Assert reset during the 2nd symbol of PULSE_Y0 -> next cycle ab=00, shadow=S0, cmd_ready=1, no done.

Source files
------------

// File: rtl/fsm_ab_driver.sv
// Initiator for the a/b two-input control FSM: turns steering commands into registered
// a/b symbols, tracks a shadow of the partner state and checks the partner's y0/y1.
module fsm_ab_driver #(
  parameter int HOLD_W    = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [HOLD_W-1:0]    cmd_arg,
  input  logic                 check_en,
  output logic                 a,
  output logic                 b,
  input  logic                 y0,
  input  logic                 y1,
  output logic                 done,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    DRV_IDLE  = 2'd0,
    DRV_DRIVE = 2'd1,
    DRV_HOLD  = 2'd2
  } drv_state_t;

  typedef enum logic [1:0] {
    P_S0 = 2'd0,
    P_S1 = 2'd1,
    P_S2 = 2'd2
  } partner_state_t;

  localparam logic [1:0] OP_GOTO_S0  = 2'd0;
  localparam logic [1:0] OP_GOTO_S1  = 2'd1;
  localparam logic [1:0] OP_PULSE_Y0 = 2'd2;
  localparam logic [1:0] OP_HOLD     = 2'd3;

  localparam logic [HOLD_W-1:0]    HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0]    HOLD_ONE  = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] ERR_ZERO  = {ERR_CNT_W{1'b0}};
  localparam logic [ERR_CNT_W-1:0] ERR_ONE   = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = {ERR_CNT_W{1'b1}};

  // Returns {last_index[1:0], sym0[1:0], sym1[1:0], sym2[1:0]} for a non-HOLD command.
  function automatic logic [7:0] seq_lookup(input logic [1:0] op, input partner_state_t s);
    logic [7:0] r;
    r = 8'h00;
    case (op)
      OP_GOTO_S0: begin
        case (s)
          P_S1:    r = {2'd0, 2'b10, 2'b00, 2'b00};
          default: r = {2'd0, 2'b00, 2'b00, 2'b00};
        endcase
      end
      OP_GOTO_S1: begin
        case (s)
          P_S1:    r = {2'd0, 2'b00, 2'b00, 2'b00};
          P_S2:    r = {2'd1, 2'b00, 2'b10, 2'b00};
          default: r = {2'd0, 2'b10, 2'b00, 2'b00};
        endcase
      end
      OP_PULSE_Y0: begin
        case (s)
          P_S1:    r = {2'd2, 2'b10, 2'b11, 2'b00};
          P_S2:    r = {2'd2, 2'b00, 2'b11, 2'b00};
          default: r = {2'd1, 2'b11, 2'b00, 2'b00};
        endcase
      end
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] sym_at(input logic [5:0] seq, input logic [1:0] idx);
    logic [1:0] r;
    case (idx)
      2'd0:    r = seq[5:4];
      2'd1:    r = seq[3:2];
      2'd2:    r = seq[1:0];
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic partner_state_t partner_next(input partner_state_t s, input logic [1:0] ab);
    partner_state_t r;
    case (s)
      P_S0: begin
        if (ab == 2'b11) begin
          r = P_S2;
        end else if (ab == 2'b10) begin
          r = P_S1;
        end else begin
          r = P_S0;
        end
      end
      P_S1:    r = ab[1] ? P_S0 : P_S1;
      default: r = P_S0;
    endcase
    return r;
  endfunction

  drv_state_t          drv_state_r, drv_state_s;
  partner_state_t      shadow_r;
  logic [1:0]          ab_r, ab_s;
  logic                done_r, done_s;
  logic [1:0]          idx_r, idx_s;
  logic [1:0]          last_r, last_s;
  logic [5:0]          seq_r, seq_s;
  logic [HOLD_W-1:0]   cnt_r, cnt_s;
  logic [7:0]          lookup_s;
  logic                exp_y0_s, exp_y1_s, err_s;
  logic                mismatch_r;
  logic [ERR_CNT_W-1:0] err_count_r;

  assign cmd_ready = (drv_state_r == DRV_IDLE);
  assign a         = ab_r[1];
  assign b         = ab_r[0];
  assign done      = done_r;
  assign mismatch  = mismatch_r;
  assign err_count = err_count_r;

  // Driver next state: a/b and done are computed one cycle ahead so they leave the flops aligned.
  always_comb begin
    drv_state_s = drv_state_r;
    ab_s        = 2'b00;
    done_s      = 1'b0;
    idx_s       = idx_r;
    last_s      = last_r;
    seq_s       = seq_r;
    cnt_s       = cnt_r;
    lookup_s    = seq_lookup(cmd_op, shadow_r);
    case (drv_state_r)
      DRV_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_HOLD) begin
            drv_state_s = DRV_HOLD;
            if (cmd_arg == HOLD_ZERO) begin
              cnt_s = HOLD_ONE;
            end else begin
              cnt_s = cmd_arg;
            end
            done_s = (cnt_s == HOLD_ONE);
          end else begin
            drv_state_s = DRV_DRIVE;
            last_s      = lookup_s[7:6];
            seq_s       = lookup_s[5:0];
            idx_s       = 2'd0;
            ab_s        = lookup_s[5:4];
            done_s      = (lookup_s[7:6] == 2'd0);
          end
        end else begin
          drv_state_s = DRV_IDLE;
        end
      end
      DRV_DRIVE: begin
        if (idx_r == last_r) begin
          drv_state_s = DRV_IDLE;
        end else begin
          idx_s  = idx_r + 2'd1;
          ab_s   = sym_at(seq_r, idx_s);
          done_s = (idx_s == last_r);
        end
      end
      DRV_HOLD: begin
        if (cnt_r <= HOLD_ONE) begin
          drv_state_s = DRV_IDLE;
        end else begin
          cnt_s  = cnt_r - HOLD_ONE;
          done_s = (cnt_s == HOLD_ONE);
        end
      end
      default: begin
        drv_state_s = DRV_IDLE;
      end
    endcase
  end

  // Partner expectations come from the shadow state and the symbol currently on a/b.
  always_comb begin
    exp_y1_s = (shadow_r != P_S2);
    exp_y0_s = (shadow_r == P_S0) && ab_r[1] && ab_r[0];
    if (check_en) begin
      err_s = (y0 != exp_y0_s) || (y1 != exp_y1_s);
    end else begin
      err_s = 1'b0;
    end
  end

  // Driver, shadow and checker registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      drv_state_r <= DRV_IDLE;
      shadow_r    <= P_S0;
      ab_r        <= 2'b00;
      done_r      <= 1'b0;
      idx_r       <= 2'd0;
      last_r      <= 2'd0;
      seq_r       <= 6'd0;
      cnt_r       <= HOLD_ZERO;
      mismatch_r  <= 1'b0;
      err_count_r <= ERR_ZERO;
    end else begin
      drv_state_r <= drv_state_s;
      shadow_r    <= partner_next(shadow_r, ab_r);
      ab_r        <= ab_s;
      done_r      <= done_s;
      idx_r       <= idx_s;
      last_r      <= last_s;
      seq_r       <= seq_s;
      cnt_r       <= cnt_s;
      if (err_s) begin
        mismatch_r <= 1'b1;
        if (err_count_r != ERR_MAX) begin
          err_count_r <= err_count_r + ERR_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_fsm_ab_driver.sv
// Scoreboard bench for fsm_ab_driver with a behavioural partner FSM driving y0/y1.
module tb_fsm_ab_driver;

  localparam int HOLD_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, cmd_valid, check_en, y0, y1, force_y1_low;
  logic [1:0]        cmd_op;
  logic [HOLD_W-1:0] cmd_arg;
  logic              cmd_ready, a, b, done, mismatch;
  logic [7:0]        err_count;
  logic              cmd_ready2, a2, b2, done2, mismatch2;
  logic [1:0]        err_count2;

  fsm_ab_driver #(.HOLD_W(HOLD_W), .ERR_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .check_en(check_en), .a(a), .b(b),
    .y0(y0), .y1(y1), .done(done), .mismatch(mismatch), .err_count(err_count)
  );

  fsm_ab_driver #(.HOLD_W(HOLD_W), .ERR_CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .check_en(check_en), .a(a2), .b(b2),
    .y0(y0), .y1(y1), .done(done2), .mismatch(mismatch2), .err_count(err_count2)
  );

  // Partner FSM: S0=0, S1=1, S2=2
  logic [1:0] p_state;
  always_ff @(posedge clk) begin
    if (reset) p_state <= 2'd0;
    else begin
      case (p_state)
        2'd0:    p_state <= (a && b) ? 2'd2 : (a ? 2'd1 : 2'd0);
        2'd1:    p_state <= a ? 2'd0 : 2'd1;
        default: p_state <= 2'd0;
      endcase
    end
  end
  assign y1 = force_y1_low ? 1'b0 : (p_state != 2'd2);
  assign y0 = (p_state == 2'd0) && a && b;

  int n_vectors = 0;
  int n_miscompares = 0;
  logic [2:0] exp_q[$];

  task automatic push_expected(input logic [1:0] op, input logic [HOLD_W-1:0] arg, input logic [1:0] ps);
    logic [1:0] syms[$];
    int n;
    syms = {};
    case (op)
      2'd0: syms.push_back((ps == 2'd1) ? 2'b10 : 2'b00);
      2'd1: begin
        if (ps == 2'd2) syms.push_back(2'b00);
        syms.push_back((ps == 2'd1) ? 2'b00 : 2'b10);
      end
      2'd2: begin
        if (ps == 2'd1) syms.push_back(2'b10);
        else if (ps == 2'd2) syms.push_back(2'b00);
        syms.push_back(2'b11);
        syms.push_back(2'b00);
      end
      default: begin
        n = (arg == 0) ? 1 : int'(arg);
        repeat (n) syms.push_back(2'b00);
      end
    endcase
    foreach (syms[i]) exp_q.push_back({syms[i], (i == syms.size() - 1)});
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [HOLD_W-1:0] arg, input bit keep_valid,
                          input logic [1:0] next_op, input logic [HOLD_W-1:0] next_arg, output int waited);
    logic [2:0] e;
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg; waited = 0;
    while (!cmd_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      n_vectors++; n_miscompares++;
      $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, want 1", cmd_ready, waited);
      cmd_valid = 1'b0;
      return;
    end
    push_expected(op, arg, p_state);
    @(negedge clk);
    if (keep_valid) begin
      cmd_op = next_op; cmd_arg = next_arg;
    end else begin
      cmd_valid = 1'b0; cmd_op = ~op; cmd_arg = 8'd200;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vectors++;
      if ({a, b, done} !== e) begin
        n_miscompares++;
        $display("FAIL symbol op=%0d: a,b,done=%b%b%b want %b", op, a, b, done, e);
      end
      n_vectors++;
      if (cmd_ready !== 1'b0) begin
        n_miscompares++;
        $display("FAIL busy_ready op=%0d: cmd_ready=%b want 0", op, cmd_ready);
      end
      @(negedge clk);
    end
    n_vectors++;
    if ({a, b, done, cmd_ready} !== 4'b0001) begin
      n_miscompares++;
      $display("FAIL idle_after op=%0d: a,b,done,ready=%b%b%b%b want 0001", op, a, b, done, cmd_ready);
    end
  endtask

  task automatic check_clean(input string tag);
    n_vectors++;
    if ({mismatch, err_count} !== 9'd0) begin
      n_miscompares++;
      $display("FAIL %s_errs: mismatch=%b err_count=%0d want 0/0", tag, mismatch, err_count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0; check_en = 1'b1; force_y1_low = 1'b0;
    repeat (3) @(negedge clk);
    n_vectors++;
    if ({a, b, done, cmd_ready, mismatch, err_count, err_count2} !== {4'b0001, 1'b0, 8'd0, 2'd0}) begin
      n_miscompares++;
      $display("FAIL reset_state: a%b b%b done%b rdy%b mm%b err%0d err2%0d want 0 0 0 1 0 0 0",
               a, b, done, cmd_ready, mismatch, err_count, err_count2);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pulse_s0();
    int w;
    send_cmd(2'd2, 8'd0, 1'b0, 2'd0, 8'd0, w);
    check_clean("pulse_s0");
  endtask

  task automatic test_goto_pulse();
    int w;
    send_cmd(2'd1, 8'd0, 1'b0, 2'd0, 8'd0, w);
    send_cmd(2'd2, 8'd0, 1'b0, 2'd0, 8'd0, w);
    send_cmd(2'd0, 8'd0, 1'b0, 2'd0, 8'd0, w);
    send_cmd(2'd1, 8'd0, 1'b0, 2'd0, 8'd0, w);
    send_cmd(2'd1, 8'd0, 1'b0, 2'd0, 8'd0, w);
    send_cmd(2'd0, 8'd0, 1'b0, 2'd0, 8'd0, w);
    check_clean("goto_pulse");
  endtask

  task automatic test_hold();
    int w;
    send_cmd(2'd3, 8'd0, 1'b0, 2'd0, 8'd0, w);
    send_cmd(2'd3, 8'd5, 1'b0, 2'd0, 8'd0, w);
    send_cmd(2'd3, 8'd1, 1'b0, 2'd0, 8'd0, w);
    check_clean("hold");
  endtask

  task automatic test_back_to_back();
    int w;
    send_cmd(2'd1, 8'd0, 1'b0, 2'd0, 8'd0, w);
    send_cmd(2'd2, 8'd0, 1'b1, 2'd3, 8'd2, w);
    send_cmd(2'd3, 8'd2, 1'b0, 2'd0, 8'd0, w);
    n_vectors++;
    if (w !== 0) begin
      n_miscompares++;
      $display("FAIL b2b_accept: waited %0d cycles after done, want 0", w);
    end
    check_clean("b2b");
  endtask

  task automatic test_checker();
    force_y1_low = 1'b1;
    repeat (3) @(negedge clk);
    force_y1_low = 1'b0;
    n_vectors++;
    if ({mismatch, err_count, mismatch2, err_count2} !== {1'b1, 8'd3, 1'b1, 2'd3}) begin
      n_miscompares++;
      $display("FAIL err_three: mm%b err%0d mm2%b err2%0d want 1 3 1 3", mismatch, err_count, mismatch2, err_count2);
    end
    force_y1_low = 1'b1;
    repeat (2) @(negedge clk);
    force_y1_low = 1'b0;
    @(negedge clk);
    n_vectors++;
    if ({mismatch, err_count, err_count2} !== {1'b1, 8'd5, 2'd3}) begin
      n_miscompares++;
      $display("FAIL err_saturate: mm%b err%0d err2%0d want 1 5 3", mismatch, err_count, err_count2);
    end
    check_en = 1'b0; force_y1_low = 1'b1;
    repeat (2) @(negedge clk);
    force_y1_low = 1'b0; check_en = 1'b1;
    @(negedge clk);
    n_vectors++;
    if ({mismatch, err_count} !== {1'b1, 8'd5}) begin
      n_miscompares++;
      $display("FAIL check_disabled: mm%b err%0d want 1 5", mismatch, err_count);
    end
  endtask

  task automatic test_reset_mid_cmd();
    int w;
    logic [2:0] e;
    send_cmd(2'd1, 8'd0, 1'b0, 2'd0, 8'd0, w);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_arg = 8'd0;
    push_expected(2'd2, 8'd0, p_state);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      n_vectors++;
      if ({a, b, done} !== e) begin
        n_miscompares++;
        $display("FAIL pre_reset_sym%0d: a,b,done=%b%b%b want %b", i, a, b, done, e);
      end
      if (i == 0) @(negedge clk);
    end
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_vectors++;
    if ({a, b, done, cmd_ready, mismatch, err_count} !== {4'b0001, 1'b0, 8'd0}) begin
      n_miscompares++;
      $display("FAIL mid_reset: a%b b%b done%b rdy%b mm%b err%0d want 0 0 0 1 0 0", a, b, done, cmd_ready, mismatch, err_count);
    end
    reset = 1'b0;
    @(negedge clk);
    n_vectors++;
    if ({a, b, done} !== 3'b000) begin
      n_miscompares++;
      $display("FAIL post_reset_done: a,b,done=%b%b%b want 000", a, b, done);
    end
    send_cmd(2'd2, 8'd0, 1'b0, 2'd0, 8'd0, w);
    check_clean("after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pulse_s0();
    test_goto_pulse();
    test_hold();
    test_back_to_back();
    test_checker();
    test_reset_mid_cmd();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
